// File: rtl/id_ex_if.sv
// Decode/WB/EX-control bundle feeding the ID/EX pipeline register and the
// registered ID/EX fields it returns. The master side is the decode stage; the slave side is the latch.
interface id_ex_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          id_valid;
  logic [RW-1:0] id_reg1;
  logic [RW-1:0] id_reg2;
  logic [RW-1:0] id_regw;
  logic          id_rw;
  logic          id_mem_rd;
  logic [2:0]    id_aluop;
  logic [DW-1:0] id_d1;
  logic [DW-1:0] id_d2;
  logic          wb_rw;
  logic [RW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          ex_hold;
  logic          flush;

  logic          ID_EX_Valid;
  logic          ID_EX_RW;
  logic          ID_EX_MemRd;
  logic [RW-1:0] ID_EX_Reg1;
  logic [RW-1:0] ID_EX_Reg2;
  logic [RW-1:0] ID_EX_RegW;
  logic [2:0]    ID_EX_AluOp;
  logic [DW-1:0] ID_EX_D1;
  logic [DW-1:0] ID_EX_D2;
  logic          id_stall;
  logic [7:0]    lu_count;

  modport master (
    output id_valid, id_reg1, id_reg2, id_regw, id_rw, id_mem_rd, id_aluop,
           id_d1, id_d2, wb_rw, wb_reg, wb_data, ex_hold, flush,
    input  ID_EX_Valid, ID_EX_RW, ID_EX_MemRd, ID_EX_Reg1, ID_EX_Reg2,
           ID_EX_RegW, ID_EX_AluOp, ID_EX_D1, ID_EX_D2, id_stall, lu_count
  );

  modport slave (
    input  id_valid, id_reg1, id_reg2, id_regw, id_rw, id_mem_rd, id_aluop,
           id_d1, id_d2, wb_rw, wb_reg, wb_data, ex_hold, flush,
    output ID_EX_Valid, ID_EX_RW, ID_EX_MemRd, ID_EX_Reg1, ID_EX_Reg2,
           ID_EX_RegW, ID_EX_AluOp, ID_EX_D1, ID_EX_D2, id_stall, lu_count
  );
endinterface

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with flush, hold, WB write-through and load-use bubble.
// Define ID_EX_LOAD_USE_EN to build the load-use interlock (LU_BUBBLE state, lu_count).
module id_ex_latch #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus,
  output logic   dbg_state
);

  typedef enum logic {
    RUN       = 1'b0,
    LU_BUBBLE = 1'b1
  } state_t;

  state_t        state;
  logic          lu;
  logic [DW-1:0] d1_next;
  logic [DW-1:0] d2_next;

`ifdef ID_EX_LOAD_USE_EN
  logic [7:0] lu_cnt;

  assign lu = (state == RUN) & bus.ID_EX_Valid & bus.ID_EX_MemRd & bus.ID_EX_RW &
              bus.id_valid & ((bus.ID_EX_RegW == bus.id_reg1) |
                              (bus.ID_EX_RegW == bus.id_reg2));
  assign bus.lu_count = lu_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt <= 8'd0;
    end else if (!bus.flush && !bus.ex_hold && lu && lu_cnt != 8'hFF) begin
      lu_cnt <= lu_cnt + 8'd1;
    end
  end
`else
  assign lu           = 1'b0;
  assign bus.lu_count = 8'd0;
`endif

  // Stall contract: while id_stall=1 the decode stage must keep its
  // instruction stable; it is taken on the first edge where id_stall=0.
  assign bus.id_stall = rst_n & ~bus.flush & (bus.ex_hold | lu);

  assign d1_next = (bus.wb_rw && bus.wb_reg == bus.id_reg1) ? bus.wb_data : bus.id_d1;
  assign d2_next = (bus.wb_rw && bus.wb_reg == bus.id_reg2) ? bus.wb_data : bus.id_d2;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      bus.ID_EX_Valid <= 1'b0;
      bus.ID_EX_RW    <= 1'b0;
      bus.ID_EX_MemRd <= 1'b0;
      bus.ID_EX_Reg1  <= '0;
      bus.ID_EX_Reg2  <= '0;
      bus.ID_EX_RegW  <= '0;
      bus.ID_EX_AluOp <= 3'd0;
      bus.ID_EX_D1    <= '0;
      bus.ID_EX_D2    <= '0;
    end else if (bus.flush || (lu && !bus.ex_hold)) begin
      // Flush and load-use bubble both load an all-zero slot.
      state           <= bus.flush ? RUN : LU_BUBBLE;
      bus.ID_EX_Valid <= 1'b0;
      bus.ID_EX_RW    <= 1'b0;
      bus.ID_EX_MemRd <= 1'b0;
      bus.ID_EX_Reg1  <= '0;
      bus.ID_EX_Reg2  <= '0;
      bus.ID_EX_RegW  <= '0;
      bus.ID_EX_AluOp <= 3'd0;
      bus.ID_EX_D1    <= '0;
      bus.ID_EX_D2    <= '0;
    end else if (!bus.ex_hold) begin
      state           <= RUN;
      bus.ID_EX_Valid <= bus.id_valid;
      bus.ID_EX_RW    <= bus.id_rw;
      bus.ID_EX_MemRd <= bus.id_mem_rd;
      bus.ID_EX_Reg1  <= bus.id_reg1;
      bus.ID_EX_Reg2  <= bus.id_reg2;
      bus.ID_EX_RegW  <= bus.id_regw;
      bus.ID_EX_AluOp <= bus.id_aluop;
      bus.ID_EX_D1    <= d1_next;
      bus.ID_EX_D2    <= d2_next;
    end
  end

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch; load-use checks follow ID_EX_LOAD_USE_EN.
module tb_id_ex_latch;

  logic clk;
  logic rst_n;
  logic dbg_state;
  int   errors = 0;
  int   checks = 0;

  id_ex_if #(.DW(16), .RW(3)) bus ();

  id_ex_latch #(.DW(16), .RW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] rw_reg, input logic wr, input logic mrd,
                       input logic [2:0] alu, input logic [15:0] d1, input logic [15:0] d2);
    bus.id_valid  = v;
    bus.id_reg1   = r1;
    bus.id_reg2   = r2;
    bus.id_regw   = rw_reg;
    bus.id_rw     = wr;
    bus.id_mem_rd = mrd;
    bus.id_aluop  = alu;
    bus.id_d1     = d1;
    bus.id_d2     = d2;
  endtask

  task automatic check_all(input string tag, input logic v, input logic wr, input logic mrd,
                           input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] rw_reg,
                           input logic [2:0] alu, input logic [15:0] d1, input logic [15:0] d2);
    check({tag, ".valid"}, bus.ID_EX_Valid, v);
    check({tag, ".rw"},    bus.ID_EX_RW, wr);
    check({tag, ".memrd"}, bus.ID_EX_MemRd, mrd);
    check({tag, ".reg1"},  bus.ID_EX_Reg1, r1);
    check({tag, ".reg2"},  bus.ID_EX_Reg2, r2);
    check({tag, ".regw"},  bus.ID_EX_RegW, rw_reg);
    check({tag, ".aluop"}, bus.ID_EX_AluOp, alu);
    check({tag, ".d1"},    bus.ID_EX_D1, d1);
    check({tag, ".d2"},    bus.ID_EX_D2, d2);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    check("reset.lu_count", bus.lu_count, 0);
    check("reset.state", dbg_state, 0);
    check("reset.stall", bus.id_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.wb_rw   = 1'b0;
    bus.wb_reg  = 3'd0;
    bus.wb_data = 16'h0;
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    do_reset();
    bus.ex_hold = 1'b0;

    // normal capture
    drive(1, 3'd1, 3'd2, 3'd4, 1, 0, 3'd5, 16'h1234, 16'h5678);
    step();
    check_all("cap", 1, 1, 0, 3'd1, 3'd2, 3'd4, 3'd5, 16'h1234, 16'h5678);

    // write-through on D2 only
    drive(1, 3'd4, 3'd5, 3'd6, 0, 0, 3'd2, 16'h2222, 16'h1111);
    bus.wb_rw = 1'b1; bus.wb_reg = 3'd5; bus.wb_data = 16'hBEEF;
    step();
    check_all("wt2", 1, 0, 0, 3'd4, 3'd5, 3'd6, 3'd2, 16'h2222, 16'hBEEF);

    // write-through on both operands
    drive(1, 3'd6, 3'd6, 3'd7, 1, 0, 3'd3, 16'hAAAA, 16'hBBBB);
    bus.wb_reg = 3'd6; bus.wb_data = 16'hC0DE;
    step();
    check("wtb.d1", bus.ID_EX_D1, 16'hC0DE);
    check("wtb.d2", bus.ID_EX_D2, 16'hC0DE);

    // matching specifier but wb_rw low
    drive(1, 3'd6, 3'd6, 3'd7, 1, 0, 3'd3, 16'hAAAA, 16'hBBBB);
    bus.wb_rw = 1'b0;
    step();
    check("nowt.d1", bus.ID_EX_D1, 16'hAAAA);
    check("nowt.d2", bus.ID_EX_D2, 16'hBBBB);

    // hold freezes everything
    drive(1, 3'd0, 3'd1, 3'd2, 0, 0, 3'd7, 16'h9999, 16'h8888);
    bus.ex_hold = 1'b1;
    #1;
    check("hold.stall", bus.id_stall, 1);
    step();
    check_all("hold", 1, 1, 0, 3'd6, 3'd6, 3'd7, 3'd3, 16'hAAAA, 16'hBBBB);

    // flush beats hold
    bus.flush = 1'b1;
    #1;
    check("flush.stall", bus.id_stall, 0);
    step();
    check_all("flush", 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    check("flush.state", dbg_state, 0);
    bus.flush = 1'b0; bus.ex_hold = 1'b0;

    // reset mid-operation
    drive(1, 3'd2, 3'd3, 3'd1, 1, 1, 3'd4, 16'h4444, 16'h5555);
    step();
    check("pre_rst.valid", bus.ID_EX_Valid, 1);
    do_reset();

`ifdef ID_EX_LOAD_USE_EN
    // load r3, then consumer of r3 -> one bubble
    drive(1, 3'd0, 3'd1, 3'd3, 1, 1, 3'd1, 16'h0101, 16'h0202);
    step();
    drive(1, 3'd3, 3'd4, 3'd5, 1, 0, 3'd2, 16'h0303, 16'h0404);
    #1;
    check("lu.stall", bus.id_stall, 1);
    step();
    check("lu.bubble_valid", bus.ID_EX_Valid, 0);
    check("lu.bubble_memrd", bus.ID_EX_MemRd, 0);
    check("lu.count1", bus.lu_count, 1);
    check("lu.state_bubble", dbg_state, 1);
    check("lu.stall_bubble", bus.id_stall, 0);
    step();
    check_all("lu.cap", 1, 1, 0, 3'd3, 3'd4, 3'd5, 3'd2, 16'h0303, 16'h0404);
    check("lu.state_run", dbg_state, 0);

    // load with RW=0 is not a hazard
    drive(1, 3'd0, 3'd0, 3'd2, 0, 1, 3'd0, 16'h0, 16'h0);
    step();
    drive(1, 3'd2, 3'd2, 3'd1, 1, 0, 3'd0, 16'h0, 16'h0);
    #1;
    check("norw.stall", bus.id_stall, 0);

    // specifier 0 hazard, then hold through the bubble, then reset mid-bubble
    do_reset();
    drive(1, 3'd1, 3'd1, 3'd0, 1, 1, 3'd0, 16'h0, 16'h0);
    step();
    drive(1, 3'd7, 3'd0, 3'd1, 1, 0, 3'd6, 16'h7777, 16'h6666);
    #1;
    check("r0.stall", bus.id_stall, 1);
    step();
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bhold.stall", bus.id_stall, 1);
      step();
      check("bhold.valid", bus.ID_EX_Valid, 0);
      check("bhold.state", dbg_state, 1);
      check("bhold.count", bus.lu_count, 1);
    end
    do_reset();
    bus.ex_hold = 1'b0;

    // saturation: 256 hazards
    for (int i = 0; i < 256; i++) begin
      drive(1, 3'd7, 3'd7, 3'd1, 1, 1, 3'd0, 16'h0, 16'h0);
      step();
      drive(1, 3'd1, 3'd2, 3'd3, 1, 0, 3'd0, 16'h0, 16'h0);
      step();
      step();
      if (i == 9) check("sat.count10", bus.lu_count, 10);
    end
    check("sat.count", bus.lu_count, 255);
`else
    // no interlock: consumer follows load directly
    drive(1, 3'd0, 3'd1, 3'd3, 1, 1, 3'd1, 16'h0101, 16'h0202);
    step();
    drive(1, 3'd3, 3'd4, 3'd5, 1, 0, 3'd2, 16'h0303, 16'h0404);
    #1;
    check("nolu.stall", bus.id_stall, 0);
    step();
    check_all("nolu.cap", 1, 1, 0, 3'd3, 3'd4, 3'd5, 3'd2, 16'h0303, 16'h0404);
    check("nolu.count", bus.lu_count, 0);
    check("nolu.state", dbg_state, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
